// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter.
// Owner encoding leaves 0 free to mean "no lock held".
package mem_arb_pkg;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 512;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_0    = 2'd1;
   localparam logic [1:0] OWN_1    = 2'd2;

   function automatic logic [1:0] own_of(input logic idx);
      return idx ? OWN_1 : OWN_0;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick: a tie goes to the port that did not win last.
module arb_rr2 (
   input  logic req0,
   input  logic req1,
   input  logic last_winner,
   output logic win,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      win   = 1'b0;
      if (req0 && req1) begin
         win = ~last_winner;
      end else if (req1) begin
         win = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between two requesters with round-robin
// grants, a bounded burst lock, and registered read return.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
   parameter int DATA_W   = mem_arb_pkg::DATA_W,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              lock0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_index,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_in,
   input  logic [DATA_W-1:0] mem_out
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LOCK);

   logic [1:0]        owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic own_vld, own_idx, own_req, oth_req, hold;
   logic rr_win, rr_vld, win, win_vld;
   logic beat_wr, beat_lock;

   arb_rr2 u_rr (
      .req0        (req0),
      .req1        (req1),
      .last_winner (last_q),
      .win         (rr_win),
      .valid       (rr_vld)
   );

   always_comb begin
      own_vld = owner_q != OWN_NONE;
      own_idx = owner_q == OWN_1;
      own_req = own_idx ? req1 : req0;
      oth_req = own_idx ? req0 : req1;
      // Owner keeps the port until the cap, unless nobody else is waiting.
      hold    = own_vld & own_req & ((cnt_q < MAX_C) | ~oth_req);
      win     = hold ? own_idx : rr_win;
      win_vld = (hold | rr_vld) & rst;
   end

   always_comb begin
      gnt0      = win_vld & ~win;
      gnt1      = win_vld & win;
      beat_wr   = win ? wr1 : wr0;
      beat_lock = win ? lock1 : lock0;
      mem_index = '0;
      mem_wr    = 1'b0;
      mem_in    = '0;
      if (win_vld) begin
         mem_index = win ? addr1 : addr0;
         mem_wr    = beat_wr;
         mem_in    = win ? wdata1 : wdata0;
      end
   end

   always_comb begin
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      if (win_vld) begin
         last_d = win;
         if (!beat_wr) begin
            if (win) begin
               rvalid1_d = 1'b1;
               rdata1_d  = mem_out;
            end else begin
               rvalid0_d = 1'b1;
               rdata0_d  = mem_out;
            end
         end
         // Any unlocked beat clears the lock, whether owner or intruder.
         if (beat_lock) begin
            if (owner_q == own_of(win)) begin
               cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
               owner_d = own_of(win);
               cnt_d   = CNT_W'(1);
            end
         end else begin
            owner_d = OWN_NONE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q   <= OWN_NONE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus for mem_arbiter against a rule-level
// model of grants, locks, memory contents and read returns.
module tb_mem_arbiter;

   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int MAXL = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req0 = 0, wr0 = 0, lock0 = 0;
   logic req1 = 0, wr1 = 0, lock1 = 0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic gnt0, gnt1, rvalid0, rvalid1, mem_wr;
   logic [DW-1:0] rdata0, rdata1, mem_in, mem_out;
   logic [AW-1:0] mem_index;

   logic [DW-1:0] tb_mem [512];
   logic [DW-1:0] ref_mem [512];

   int n_cmp = 0;
   int n_bad = 0;

   int m_owner, m_cnt, m_last;
   logic m_rv [2];
   logic [DW-1:0] m_rd [2];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) tb_mem[mem_index] <= mem_in;
   end
   assign mem_out = tb_mem[mem_index];

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_index(mem_index), .mem_wr(mem_wr), .mem_in(mem_in),
      .mem_out(mem_out)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 1;
      m_rv[0] = 0;
      m_rv[1] = 0;
      m_rd[0] = '0;
      m_rd[1] = '0;
   endtask

   function automatic int model_win();
      logic r [2];
      r[0] = req0;
      r[1] = req1;
      if (m_owner >= 0 && r[m_owner] && (m_cnt < MAXL || !r[1-m_owner]))
         return m_owner;
      if (r[0] && r[1]) return 1 - m_last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
   endfunction

   task automatic model_beat(input int w);
      logic          bwr, blk;
      logic [AW-1:0] ba;
      logic [DW-1:0] bd;
      m_rv[0] = 0;
      m_rv[1] = 0;
      if (w < 0) return;
      bwr = (w == 1) ? wr1 : wr0;
      blk = (w == 1) ? lock1 : lock0;
      ba  = (w == 1) ? addr1 : addr0;
      bd  = (w == 1) ? wdata1 : wdata0;
      if (bwr) ref_mem[ba] = bd;
      else begin
         m_rd[w] = ref_mem[ba];
         m_rv[w] = 1;
      end
      m_last = w;
      if (blk) begin
         if (m_owner == w) m_cnt = (m_cnt < MAXL) ? m_cnt + 1 : MAXL;
         else begin
            m_owner = w;
            m_cnt   = 1;
         end
      end else begin
         m_owner = -1;
         m_cnt   = 0;
      end
   endtask

   task automatic step(output int w);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      #2;
      w  = model_win();
      ea = (w == 1) ? addr1 : (w == 0) ? addr0 : '0;
      ed = (w == 1) ? wdata1 : (w == 0) ? wdata0 : '0;
      chk("gnt0", 32'(gnt0), 32'(w == 0));
      chk("gnt1", 32'(gnt1), 32'(w == 1));
      chk("mem_wr", 32'(mem_wr),
          32'(w >= 0 && ((w == 1) ? wr1 : wr0)));
      chk("mem_index", 32'(mem_index), 32'(ea));
      chk("mem_in", mem_in, ed);
      chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
      chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
      @(posedge clk);
      model_beat(w);
      #1;
   endtask

   task automatic set0(input logic r, input logic w, input int a,
                       input logic [DW-1:0] d, input logic l);
      req0 = r; wr0 = w; addr0 = AW'(a); wdata0 = d; lock0 = l;
   endtask

   task automatic set1(input logic r, input logic w, input int a,
                       input logic [DW-1:0] d, input logic l);
      req1 = r; wr1 = w; addr1 = AW'(a); wdata1 = d; lock1 = l;
   endtask

   initial begin
      int  w;
      int  seq0 [$];
      bit  pend0, pend1;

      for (int i = 0; i < 512; i++) begin
         tb_mem[i]  = $urandom;
         ref_mem[i] = tb_mem[i];
      end
      model_reset();

      // reset then idle
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      step(w);
      step(w);

      // single port 1 write then read
      set1(1, 1, 5, 32'hDEADBEEF, 0);
      step(w);
      set1(1, 0, 5, 0, 0);
      step(w);
      set1(0, 0, 0, 0, 0);
      step(w);
      chk("rt_rdata1", rdata1, 32'hDEADBEEF);

      // tie round robin
      set0(1, 0, 1, 0, 0);
      set1(1, 0, 2, 0, 0);
      seq0.delete();
      repeat (4) begin
         step(w);
         seq0.push_back(w);
      end
      chk("rr_order", 32'({seq0[0][1:0], seq0[1][1:0],
                            seq0[2][1:0], seq0[3][1:0]}), 32'h11);
      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      step(w);

      // lock starvation bound
      set0(1, 0, 7, 0, 1);
      set1(1, 0, 8, 0, 0);
      for (int i = 0; i < MAXL + 1; i++) begin
         step(w);
         chk("lock_beat", 32'(w), (i < MAXL) ? 32'd0 : 32'd1);
      end
      lock0 = 1'b0;
      repeat (4) step(w);
      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      step(w);

      // lock release after beat 4
      set0(1, 0, 10, 0, 1);
      set1(1, 0, 11, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) lock0 = 1'b0;
         if (i == 4) set0(0, 0, 0, 0, 0);
         step(w);
         if (i == 4) chk("release_gnt", 32'(w), 32'd1);
      end
      chk("release_owner", 32'(m_owner), 32'hFFFFFFFF);
      set1(0, 0, 0, 0, 0);
      step(w);

      // reset during a locked read burst
      set0(1, 0, 3, 0, 1);
      step(w);
      step(w);
      #2 rst = 1'b0;
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_rvalid0", 32'(rvalid0), 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      rst = 1'b1;
      set0(1, 0, 4, 0, 0);
      set1(1, 0, 6, 0, 0);
      step(w);
      chk("post_rst_tie", 32'(w), 32'd0);
      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      step(w);

      // random traffic, requests held until granted
      pend0 = 0;
      pend1 = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pend0)
            set0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15), $urandom, $urandom_range(0, 1) == 1);
         if (!pend1)
            set1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15), $urandom, $urandom_range(0, 1) == 1);
         step(w);
         pend0 = req0 && (w != 0);
         pend1 = req1 && (w != 1);
      end
      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      step(w);
      step(w);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 512x32 Memory between two requesters: port 0 (convolution engine) and port 1 (host loader/debug).
- Sits between both requesters and the Memory's index/wr/in/out pins, and drives those pins directly.
- Grants are two-way round-robin with an optional bounded lock for bursts (e.g. a filter-window fetch).
- Read data is registered and returned with a valid pulse.

Parameters:
ADDR_W, 9, memory index width (512 words)
DATA_W, 32, memory word width
MAX_LOCK, 8, max consecutive locked beats before a waiting requester is forced in (>=1)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 access request
wr0  in  1  1=write, 0=read
addr0  in  ADDR_W  word index
wdata0  in  DATA_W  write data
lock0  in  1  keep ownership after this beat
gnt0  out  1  access accepted this cycle (combinational)
rvalid0  out  1  one-cycle pulse: rdata0 holds read result
rdata0  out  DATA_W  registered read data
req1/wr1/addr1/wdata1/lock1/gnt1/rvalid1/rdata1  same as port 0, for requester 1
mem_index  out  ADDR_W  to Memory index
mem_wr  out  1  to Memory write enable
mem_in  out  DATA_W  to Memory write data
mem_out  in  DATA_W  from Memory; combinational read of mem_index

Behaviour:
- Beat = cycle with req_i & gnt_i. It completes at that rising edge.
- At most one gnt per cycle. A requester never gets gnt while its req=0.
- Winner selection, combinational, in priority order:
  1. Owner lock: lock_owner valid, its req=1, and (lock_cnt < MAX_LOCK or other req=0) -> owner wins.
  2. Single request -> that requester wins.
  3. Both request -> the requester != last_winner wins.
- Memory drive follows the winner: mem_index/mem_wr/mem_in come from the winner's addr/wr/wdata.
- With no winner: mem_wr=0, mem_index=0, mem_in=0. A write commits in Memory at the beat edge.
- Read beat on port i: rdata_i <= mem_out at the beat edge, and rvalid_i=1 for exactly the next cycle.
  - rdata_i holds its value until the next read beat on port i.
  - Back-to-back reads give back-to-back rvalid pulses.
  - A write beat does not change rdata_i or rvalid_i.
- last_winner <= winner on every beat; unchanged on idle cycles.
- Lock state (lock_owner, lock_cnt, width clog2(MAX_LOCK+1)):
  - Beat with lock_i=1 and i already owner: lock_cnt <= lock_cnt+1, saturating at MAX_LOCK.
  - Beat with lock_i=1 and i not owner: lock_owner <= i, lock_cnt <= 1.
  - Beat with lock_i=0 by the owner: lock released, lock_cnt <= 0.
  - Owner drops req while locked: lock held, and the other requester may be granted in the meantime.
    - Lock is cleared if the other requester completes a beat.
  - Forced release: owner at lock_cnt == MAX_LOCK while the other requests -> other wins by rule 3 and the lock is cleared at that beat.
  - Guarantees a waiting requester is served within MAX_LOCK+1 cycles.
- Reset (rst=0, async):
  - gnt and rvalid low, rdata0/rdata1=0.
  - lock_owner=none, lock_cnt=0, last_winner=1 (port 0 wins the first tie).
  - Mid-burst reset drops the lock and any pending rvalid immediately.
- gnt_i may depend combinationally on req_i/lock state. Requesters must hold addr/wr/wdata stable while req=1 and gnt=0.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, owner encoding constants (OWN_NONE, OWN_0, OWN_1), MEM_DEPTH=512.
- One sub-module: arb_rr2, a pure combinational 2-way round-robin pick from (req0, req1, last_winner) -> winner/valid.
- Lock/counter/rdata logic stays in mem_arbiter.

Test Plan:
- Reset then idle: rst low 3 cycles then high, no req -> all gnt/rvalid 0, mem_wr=0, mem_index=0, rdata=0.
- Single port: port1 writes 0xDEADBEEF to index 5, next cycle reads index 5 -> gnt1 both cycles; rvalid1 one cycle after the read beat with rdata1=0xDEADBEEF; rdata0 unchanged.
- Tie round-robin: both req reads of indices 1 and 2 held 4 cycles, no lock -> grants alternate 0,1,0,1; rvalid0/rvalid1 alternate with the matching data.
- Lock starvation bound, MAX_LOCK=8: port0 requests with lock0=1 continuously and port1 requests from the same cycle -> port0 wins 8 beats, port1 wins beat 9, then alternation resumes.
- Lock release: port0 locks 3 beats then beat 4 with lock0=0 while port1 waits from the start -> port1 granted on cycle 5, lock_owner none.
- Reset mid-burst: assert rst during a locked read beat -> rvalid0 stays 0 next cycle, lock cleared; after release the first tie goes to port0.
